// File: rtl/pong_ball_engine_if.sv
// Pause control, paddle geometry and ball/score outputs of the pong ball engine.
// The engine takes the slave view; the driver of paddles and the consumer of the ball take the master view.
interface pong_ball_engine_if;
  logic       enable;
  logic [9:0] Paddle1X;
  logic [9:0] Paddle1Y;
  logic [9:0] Paddle1W;
  logic [9:0] Paddle1L;
  logic [9:0] Paddle2X;
  logic [9:0] Paddle2Y;
  logic [9:0] Paddle2W;
  logic [9:0] Paddle2L;
  logic [9:0] BallX;
  logic [9:0] BallY;
  logic [9:0] BallS;
  logic [3:0] scoreL;
  logic [3:0] scoreR;
  logic [1:0] state;
  logic [1:0] winner;
  logic       resetB;

  modport master (
    output enable,
    output Paddle1X, Paddle1Y, Paddle1W, Paddle1L,
    output Paddle2X, Paddle2Y, Paddle2W, Paddle2L,
    input  BallX, BallY, BallS, scoreL, scoreR, state, winner, resetB
  );

  modport slave (
    input  enable,
    input  Paddle1X, Paddle1Y, Paddle1W, Paddle1L,
    input  Paddle2X, Paddle2Y, Paddle2W, Paddle2L,
    output BallX, BallY, BallS, scoreL, scoreR, state, winner, resetB
  );
endinterface

// File: rtl/pong_ball_engine.sv
// Two-player pong ball engine: one step per frame_clk edge covering motion, wall/paddle bounces,
// goals, scoring, serve delay, rally speed-up and game-over.
module pong_ball_engine #(
  parameter int X_MIN            = 33,
  parameter int X_MAX            = 596,
  parameter int Y_MIN            = 20,
  parameter int Y_MAX            = 461,
  parameter int X_CENTER         = 320,
  parameter int Y_CENTER         = 240,
  parameter int BALL_SIZE        = 4,
  parameter int X_STEP           = 4,
  parameter int SPEED_MAX        = 8,
  parameter int HITS_PER_SPEEDUP = 4,
  parameter int DEFLECT_SHIFT    = 3,
  parameter int SERVE_FRAMES     = 60,
  parameter int WIN_SCORE        = 9
) (
  input  logic              frame_clk,
  input  logic              Reset,
  pong_ball_engine_if.slave bus
);

  typedef enum logic [1:0] {
    ST_SERVE    = 2'b00,
    ST_PLAY     = 2'b01,
    ST_POINT    = 2'b10,
    ST_GAMEOVER = 2'b11
  } state_t;

  localparam int TW = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;
  localparam logic [TW-1:0]      TIMER_LAST = TW'(SERVE_FRAMES - 1);
  localparam logic signed [11:0] XMIN_C     = 12'(X_MIN);
  localparam logic signed [11:0] XMAX_C     = 12'(X_MAX);
  localparam logic signed [11:0] YMIN_C     = 12'(Y_MIN);
  localparam logic signed [11:0] YMAX_C     = 12'(Y_MAX);
  localparam logic signed [11:0] SIZE_C     = 12'(BALL_SIZE);
  localparam logic signed [11:0] SMAX_C     = 12'(SPEED_MAX);
  localparam logic signed [11:0] STEP_C     = 12'(X_STEP);
  localparam logic [9:0]         XC_C       = 10'(X_CENTER);
  localparam logic [9:0]         YC_C       = 10'(Y_CENTER);
  localparam logic signed [9:0]  VX_STEP_C  = 10'(X_STEP);
  localparam logic [7:0]         HPS_C      = 8'(HITS_PER_SPEEDUP);
  localparam logic [3:0]         WIN_C      = 4'(WIN_SCORE);

  function automatic logic signed [11:0] zx(input logic [9:0] v);
    return signed'({2'b00, v});
  endfunction

  function automatic logic signed [11:0] sx(input logic signed [9:0] v);
    return signed'({{2{v[9]}}, v});
  endfunction

  state_t            state_q, state_d;
  logic [9:0]        x_q, x_d, y_q, y_d;
  logic signed [9:0] vx_q, vx_d, vy_q, vy_d;
  logic [3:0]        score_l_q, score_l_d, score_r_q, score_r_d;
  logic [7:0]        hits_q, hits_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [1:0]        winner_q, winner_d;
  logic              resetb_q, resetb_d;

  logic signed [11:0] nx, ny;
  logic [7:0]         hits_inc;
  logic signed [11:0] spd_raw;
  logic signed [9:0]  speed;
  logic signed [9:0]  vy_m, vy_abs;

  assign nx       = zx(x_q) + sx(vx_q);
  assign ny       = zx(y_q) + sx(vy_q);
  assign hits_inc = (hits_q == 8'hFF) ? hits_q : hits_q + 8'd1;
  // Speed is taken from the count including the current hit, so the 4th hit is the first faster return.
  assign spd_raw  = STEP_C + signed'({4'b0000, hits_inc / HPS_C});
  assign speed    = (spd_raw > SMAX_C) ? SMAX_C[9:0] : spd_raw[9:0];

  logic [9:0]        pad_x [2];
  logic [9:0]        pad_y [2];
  logic [9:0]        pad_w [2];
  logic [9:0]        pad_l [2];
  logic              approach [2];
  logic              pad_hit [2];
  logic signed [9:0] pad_vy [2];

  assign pad_x[0]    = bus.Paddle1X;
  assign pad_y[0]    = bus.Paddle1Y;
  assign pad_w[0]    = bus.Paddle1W;
  assign pad_l[0]    = bus.Paddle1L;
  assign pad_x[1]    = bus.Paddle2X;
  assign pad_y[1]    = bus.Paddle2Y;
  assign pad_w[1]    = bus.Paddle2W;
  assign pad_l[1]    = bus.Paddle2L;
  assign approach[0] = (vx_q < 10'sd0);
  assign approach[1] = (vx_q > 10'sd0);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_pad
      logic signed [11:0] dy, defl;
      // X overlap uses the next position, Y overlap the current one.
      assign pad_hit[gi] = approach[gi]
                        && (nx - SIZE_C <= zx(pad_x[gi]) + zx(pad_w[gi]))
                        && (nx + SIZE_C >= zx(pad_x[gi]) - zx(pad_w[gi]))
                        && (zx(y_q) - SIZE_C <= zx(pad_y[gi]) + zx(pad_l[gi]))
                        && (zx(y_q) + SIZE_C >= zx(pad_y[gi]) - zx(pad_l[gi]));
      assign dy          = zx(y_q) - zx(pad_y[gi]);
      assign defl        = dy >>> DEFLECT_SHIFT;
      assign pad_vy[gi]  = (defl > SMAX_C)  ? SMAX_C[9:0] :
                           (defl < -SMAX_C) ? 10'(-SMAX_C) : defl[9:0];
    end
  endgenerate

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    vx_d      = vx_q;
    vy_d      = vy_q;
    score_l_d = score_l_q;
    score_r_d = score_r_q;
    hits_d    = hits_q;
    timer_d   = timer_q;
    winner_d  = winner_q;
    resetb_d  = resetb_q;
    vy_m      = vy_q;
    vy_abs    = vy_q;
    if (bus.enable) begin
      resetb_d = 1'b0;
      unique case (state_q)
        ST_SERVE: begin
          x_d  = XC_C;
          y_d  = YC_C;
          vy_d = '0;
          if (timer_q == TIMER_LAST) begin
            timer_d = '0;
            state_d = ST_PLAY;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
        ST_PLAY: begin
          x_d    = nx[9:0];
          vy_m   = pad_hit[0] ? pad_vy[0] : (pad_hit[1] ? pad_vy[1] : vy_q);
          vy_abs = vy_m[9] ? -vy_m : vy_m;
          if (ny - SIZE_C <= YMIN_C) begin
            y_d  = 10'(YMIN_C + SIZE_C);
            vy_d = vy_abs;
          end else if (ny + SIZE_C >= YMAX_C) begin
            y_d  = 10'(YMAX_C - SIZE_C);
            vy_d = -vy_abs;
          end else begin
            y_d  = ny[9:0];
            vy_d = vy_m;
          end
          if (pad_hit[0]) begin
            vx_d   = speed;
            hits_d = hits_inc;
          end else if (pad_hit[1]) begin
            vx_d   = -speed;
            hits_d = hits_inc;
          end else if (nx - SIZE_C <= XMIN_C) begin
            score_r_d = score_r_q + 4'd1;
            resetb_d  = 1'b1;
            state_d   = ST_POINT;
          end else if (nx + SIZE_C >= XMAX_C) begin
            score_l_d = score_l_q + 4'd1;
            resetb_d  = 1'b1;
            state_d   = ST_POINT;
          end
        end
        ST_POINT: begin
          x_d     = XC_C;
          y_d     = YC_C;
          vy_d    = '0;
          hits_d  = '0;
          timer_d = '0;
          // vx still points at the goal that was crossed, i.e. toward the player who conceded.
          vx_d    = vx_q[9] ? -VX_STEP_C : VX_STEP_C;
          if (score_l_q == WIN_C) begin
            winner_d = 2'b01;
            state_d  = ST_GAMEOVER;
          end else if (score_r_q == WIN_C) begin
            winner_d = 2'b10;
            state_d  = ST_GAMEOVER;
          end else begin
            state_d = ST_SERVE;
          end
        end
        ST_GAMEOVER: begin
          x_d = XC_C;
          y_d = YC_C;
        end
      endcase
    end
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= ST_SERVE;
      x_q       <= XC_C;
      y_q       <= YC_C;
      vx_q      <= VX_STEP_C;
      vy_q      <= '0;
      score_l_q <= '0;
      score_r_q <= '0;
      hits_q    <= '0;
      timer_q   <= '0;
      winner_q  <= 2'b00;
      resetb_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      vx_q      <= vx_d;
      vy_q      <= vy_d;
      score_l_q <= score_l_d;
      score_r_q <= score_r_d;
      hits_q    <= hits_d;
      timer_q   <= timer_d;
      winner_q  <= winner_d;
      resetb_q  <= resetb_d;
    end
  end

  assign bus.BallX  = x_q;
  assign bus.BallY  = y_q;
  assign bus.BallS  = 10'(BALL_SIZE);
  assign bus.scoreL = score_l_q;
  assign bus.scoreR = score_r_q;
  assign bus.state  = state_q;
  assign bus.winner = winner_q;
  assign bus.resetB = resetb_q;

endmodule

// File: tb/tb_pong_ball_engine.sv
// Directed bench for pong_ball_engine: serve, goals, paddle deflection, walls, speed-up, pause, game-over.
`timescale 1ns/1ps
module tb_pong_ball_engine;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;

  pong_ball_engine_if bus ();

  pong_ball_engine dut (
    .frame_clk (clk),
    .Reset     (rst),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_pad1(input int x, input int w, input int y, input int l);
    bus.Paddle1X = 10'(x); bus.Paddle1W = 10'(w); bus.Paddle1Y = 10'(y); bus.Paddle1L = 10'(l);
  endtask

  task automatic set_pad2(input int x, input int w, input int y, input int l);
    bus.Paddle2X = 10'(x); bus.Paddle2W = 10'(w); bus.Paddle2Y = 10'(y); bus.Paddle2L = 10'(l);
  endtask

  task automatic apply_reset();
    #2 rst = 1'b1;
    tick(1);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    bus.enable = 1'b0;
    set_pad1(0, 0, 0, 0);
    set_pad2(0, 0, 0, 0);
    tick(1);
    total++; if (bus.BallX !== 10'd320) begin bad++; $display("FAIL reset_ballx got=%0d exp=320", bus.BallX); end
    total++; if (bus.BallY !== 10'd240) begin bad++; $display("FAIL reset_bally got=%0d exp=240", bus.BallY); end
    total++; if (bus.BallS !== 10'd4) begin bad++; $display("FAIL reset_balls got=%0d exp=4", bus.BallS); end
    total++; if (bus.scoreL !== 4'd0 || bus.scoreR !== 4'd0) begin bad++; $display("FAIL reset_scores got=%0d/%0d exp=0/0", bus.scoreL, bus.scoreR); end
    total++; if (bus.state !== 2'b00 || bus.winner !== 2'b00 || bus.resetB !== 1'b0) begin bad++; $display("FAIL reset_flags state=%b winner=%b resetB=%b exp=00/00/0", bus.state, bus.winner, bus.resetB); end
    rst = 1'b0;
    $display("test_reset: done");
  endtask

  task automatic test_serve();
    bus.enable = 1'b1;
    tick(59);
    total++; if (bus.state !== 2'b00 || bus.BallX !== 10'd320) begin bad++; $display("FAIL serve_hold state=%b x=%0d exp=00/320", bus.state, bus.BallX); end
    tick(1);
    total++; if (bus.state !== 2'b01 || bus.BallX !== 10'd320) begin bad++; $display("FAIL serve_to_play state=%b x=%0d exp=01/320", bus.state, bus.BallX); end
    tick(1);
    total++; if (bus.BallX !== 10'd324) begin bad++; $display("FAIL serve_step1 got=%0d exp=324", bus.BallX); end
    tick(1);
    total++; if (bus.BallX !== 10'd328 || bus.BallY !== 10'd240) begin bad++; $display("FAIL serve_step2 x=%0d y=%0d exp=328/240", bus.BallX, bus.BallY); end
    $display("test_serve: done");
  endtask

  task automatic test_left_point();
    tick(66);
    total++; if (bus.state !== 2'b10 || bus.resetB !== 1'b1 || bus.BallX !== 10'd592) begin bad++; $display("FAIL lpoint_enter state=%b resetB=%b x=%0d exp=10/1/592", bus.state, bus.resetB, bus.BallX); end
    total++; if (bus.scoreL !== 4'd1 || bus.scoreR !== 4'd0) begin bad++; $display("FAIL lpoint_score got=%0d/%0d exp=1/0", bus.scoreL, bus.scoreR); end
    tick(1);
    total++; if (bus.state !== 2'b00 || bus.resetB !== 1'b0 || bus.BallX !== 10'd320 || bus.BallY !== 10'd240) begin bad++; $display("FAIL lpoint_exit state=%b resetB=%b x=%0d y=%0d exp=00/0/320/240", bus.state, bus.resetB, bus.BallX, bus.BallY); end
    tick(60);
    total++; if (bus.state !== 2'b01) begin bad++; $display("FAIL lpoint_reserve state=%b exp=01", bus.state); end
    tick(1);
    total++; if (bus.BallX !== 10'd324) begin bad++; $display("FAIL lpoint_serve_dir got=%0d exp=324", bus.BallX); end
    $display("test_left_point: done");
  endtask

  task automatic test_reset_mid_play();
    #2 rst = 1'b1;
    #1;
    total++; if (bus.BallX !== 10'd320 || bus.BallY !== 10'd240 || bus.state !== 2'b00 || bus.scoreL !== 4'd0) begin bad++; $display("FAIL async_reset x=%0d y=%0d state=%b scoreL=%0d exp=320/240/00/0", bus.BallX, bus.BallY, bus.state, bus.scoreL); end
    @(posedge clk);
    #1 rst = 1'b0;
    $display("test_reset_mid_play: done");
  endtask

  task automatic test_pause();
    tick(30);
    bus.enable = 1'b0;
    tick(10);
    total++; if (bus.state !== 2'b00 || bus.BallX !== 10'd320) begin bad++; $display("FAIL pause_serve state=%b x=%0d exp=00/320", bus.state, bus.BallX); end
    bus.enable = 1'b1;
    tick(29);
    total++; if (bus.state !== 2'b00) begin bad++; $display("FAIL pause_timer_held state=%b exp=00", bus.state); end
    tick(1);
    total++; if (bus.state !== 2'b01) begin bad++; $display("FAIL pause_timer_done state=%b exp=01", bus.state); end
    tick(2);
    bus.enable = 1'b0;
    tick(10);
    total++; if (bus.BallX !== 10'd328 || bus.BallY !== 10'd240 || bus.state !== 2'b01 || bus.scoreL !== 4'd0) begin bad++; $display("FAIL pause_play x=%0d y=%0d state=%b scoreL=%0d exp=328/240/01/0", bus.BallX, bus.BallY, bus.state, bus.scoreL); end
    bus.enable = 1'b1;
    tick(1);
    total++; if (bus.BallX !== 10'd332) begin bad++; $display("FAIL pause_resume got=%0d exp=332", bus.BallX); end
    $display("test_pause: done");
  endtask

  // Right paddle returns the serve straight; left paddle sits off-centre to deflect.
  task automatic test_paddle_deflect(input int p1y, input int exp_y);
    apply_reset();
    bus.enable = 1'b1;
    set_pad1(40, 4, p1y, 24);
    set_pad2(400, 4, 240, 24);
    tick(60);
    tick(18);
    total++; if (bus.BallX !== 10'd392 || bus.BallY !== 10'd240) begin bad++; $display("FAIL deflect_p2_hit x=%0d y=%0d exp=392/240", bus.BallX, bus.BallY); end
    tick(86);
    total++; if (bus.BallX !== 10'd48 || bus.state !== 2'b01) begin bad++; $display("FAIL deflect_p1_reach x=%0d state=%b exp=48/01", bus.BallX, bus.state); end
    tick(1);
    total++; if (bus.BallX !== 10'd52 || bus.BallY !== 10'(exp_y)) begin bad++; $display("FAIL deflect_p1_out x=%0d y=%0d exp=52/%0d", bus.BallX, bus.BallY, exp_y); end
    $display("test_paddle_deflect p1y=%0d: done", p1y);
  endtask

  task automatic test_right_point();
    apply_reset();
    bus.enable = 1'b1;
    set_pad1(0, 0, 0, 0);
    set_pad2(400, 4, 240, 24);
    tick(78);
    tick(89);
    total++; if (bus.state !== 2'b10 || bus.scoreR !== 4'd1 || bus.scoreL !== 4'd0 || bus.BallX !== 10'd36) begin bad++; $display("FAIL rpoint_enter state=%b score=%0d/%0d x=%0d exp=10/0/1/36", bus.state, bus.scoreL, bus.scoreR, bus.BallX); end
    tick(61);
    total++; if (bus.state !== 2'b01) begin bad++; $display("FAIL rpoint_reserve state=%b exp=01", bus.state); end
    tick(1);
    total++; if (bus.BallX !== 10'd316) begin bad++; $display("FAIL rpoint_serve_dir got=%0d exp=316", bus.BallX); end
    $display("test_right_point: done");
  endtask

  task automatic test_walls(input int p2y, input int y43, input int y44, input int y45);
    apply_reset();
    bus.enable = 1'b1;
    set_pad1(0, 0, 0, 0);
    set_pad2(400, 4, p2y, 48);
    tick(78);
    total++; if (bus.BallX !== 10'd392) begin bad++; $display("FAIL wall_setup x=%0d exp=392", bus.BallX); end
    tick(43);
    total++; if (bus.BallY !== 10'(y43)) begin bad++; $display("FAIL wall_approach y=%0d exp=%0d", bus.BallY, y43); end
    tick(1);
    total++; if (bus.BallY !== 10'(y44)) begin bad++; $display("FAIL wall_clamp y=%0d exp=%0d", bus.BallY, y44); end
    tick(1);
    total++; if (bus.BallY !== 10'(y45) || bus.BallX !== 10'd212) begin bad++; $display("FAIL wall_reflect y=%0d x=%0d exp=%0d/212", bus.BallY, bus.BallX, y45); end
    $display("test_walls p2y=%0d: done", p2y);
  endtask

  task automatic test_speedup();
    int prev_x, prev_dx, dx, revs, mag3, mag4, mag8;
    apply_reset();
    bus.enable = 1'b1;
    set_pad1(40, 4, 240, 24);
    set_pad2(400, 4, 240, 24);
    tick(60);
    prev_x = 320; prev_dx = 4; revs = 0; mag3 = -1; mag4 = -1; mag8 = -1;
    for (int f = 0; f < 1500 && revs < 8; f++) begin
      tick(1);
      dx = int'(bus.BallX) - prev_x;
      if ((dx < 0) != (prev_dx < 0)) begin
        revs++;
        if (revs == 3) mag3 = (dx < 0) ? -dx : dx;
        if (revs == 4) mag4 = (dx < 0) ? -dx : dx;
        if (revs == 8) mag8 = (dx < 0) ? -dx : dx;
      end
      prev_x = int'(bus.BallX);
      prev_dx = dx;
    end
    total++; if (revs != 8) begin bad++; $display("FAIL speedup_hits got=%0d exp=8 (frame budget)", revs); end
    total++; if (mag3 != 4) begin bad++; $display("FAIL speedup_hit3 got=%0d exp=4", mag3); end
    total++; if (mag4 != 5) begin bad++; $display("FAIL speedup_hit4 got=%0d exp=5", mag4); end
    total++; if (mag8 != 6) begin bad++; $display("FAIL speedup_hit8 got=%0d exp=6", mag8); end
    $display("test_speedup: done");
  endtask

  task automatic test_gameover();
    apply_reset();
    bus.enable = 1'b1;
    set_pad1(0, 0, 0, 0);
    set_pad2(0, 0, 0, 0);
    for (int i = 1; i <= 9; i++) begin
      tick(128);
      total++; if (bus.state !== 2'b10 || bus.scoreL !== 4'(i)) begin bad++; $display("FAIL gameover_point%0d state=%b scoreL=%0d exp=10/%0d", i, bus.state, bus.scoreL, i); end
      tick(1);
      if (i < 9) begin
        total++; if (bus.state !== 2'b00 || bus.winner !== 2'b00) begin bad++; $display("FAIL gameover_serve%0d state=%b winner=%b exp=00/00", i, bus.state, bus.winner); end
      end
    end
    total++; if (bus.state !== 2'b11 || bus.winner !== 2'b01 || bus.BallX !== 10'd320 || bus.scoreL !== 4'd9) begin bad++; $display("FAIL gameover_enter state=%b winner=%b x=%0d scoreL=%0d exp=11/01/320/9", bus.state, bus.winner, bus.BallX, bus.scoreL); end
    for (int f = 0; f < 100; f++) begin
      tick(1);
      total++;
      if (bus.state !== 2'b11 || bus.winner !== 2'b01 || bus.BallX !== 10'd320 || bus.BallY !== 10'd240 ||
          bus.scoreL !== 4'd9 || bus.scoreR !== 4'd0 || bus.resetB !== 1'b0) begin
        bad++;
        $display("FAIL gameover_hold frame=%0d state=%b winner=%b x=%0d y=%0d score=%0d/%0d resetB=%b exp=11/01/320/240/9/0/0",
                 f, bus.state, bus.winner, bus.BallX, bus.BallY, bus.scoreL, bus.scoreR, bus.resetB);
      end
    end
    $display("test_gameover: done");
  endtask

  initial begin
    test_reset();
    test_serve();
    test_left_point();
    test_reset_mid_play();
    test_pause();
    test_paddle_deflect(224, 242);
    test_paddle_deflect(256, 238);
    test_right_point();
    test_walls(280, 25, 24, 29);
    test_walls(200, 455, 457, 452);
    test_speedup();
    test_gameover();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
